// File: rtl/sr169_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sr169_count_ctrl
//  Description : Initiator/driver for a 4-bit loadable up/down counter of the
//                169 family (active-low load, active-low count enable,
//                up_downbar direction, Q and registered TC returned).
//                A request is taken on a start/busy handshake. The counter
//                is loaded, then enabled until it reaches the terminal value.
//                At that point done pulses and ticks reports how many enables
//                were issued. A shadow copy of the expected counter value is
//                compared against Q every RUN cycle, and a disagreement raises
//                a sticky err flag.
//
//  Ports
//    clock       in   rising-edge clock
//    reset       in   asynchronous, active-high; returns the block to IDLE
//    start       in   request strobe, sampled only in IDLE
//    start_val   in   [WIDTH] value loaded into the counter
//    dir_up      in   1 = count up to all-ones (TC), 0 = count down to zero
//    hold        in   pauses counting while high (RUN only)
//    abort       in   cancels the operation; outranks everything but reset
//    cnt_q       in   [WIDTH] counter Q
//    cnt_tc      in   counter terminal count (registered, aligned with Q)
//    par_data    out  [WIDTH] counter parallel input
//    load_n      out  counter parallel enable, active low
//    cnt_en_n    out  counter count enable, active low
//    up_downbar  out  counter direction
//    busy        out  high from LOAD through DONE inclusive
//    done        out  one-cycle completion pulse
//    ticks       out  [WIDTH] enables issued in the last run, held until the
//                     next accepted start
//    err         out  sticky mismatch flag, cleared by an accepted start
//
//  Revision    : 1.0  initial release
// ============================================================================
module sr169_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic             dir_up,
    input  logic             hold,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    input  logic             cnt_tc,
    output logic [WIDTH-1:0] par_data,
    output logic             load_n,
    output logic             cnt_en_n,
    output logic             up_downbar,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ticks,
    output logic             err
);

    localparam logic [WIDTH-1:0] C_ZERO     = '0;
    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_val;      // value captured at start
    logic             r_dir;      // direction captured at start
    logic [WIDTH-1:0] r_shadow;   // value the counter should be showing
    logic [WIDTH-1:0] r_ticks;    // enables issued so far in this run
    logic             r_err;

    logic             w_accept;
    logic             w_mismatch;
    logic             w_terminal;
    logic             w_step;
    logic             w_load_shadow;
    logic             w_set_err;

    // ------------------------------------------------------------------
    // Decode of the counter feedback.
    // In the up direction TC must track Q==all-ones exactly; in the down
    // direction TC is not relied upon, so only Q is checked.
    // ------------------------------------------------------------------
    assign w_mismatch = (cnt_q != r_shadow) ||
                        (r_dir && (cnt_tc != (cnt_q == C_ALL_ONES)));

    // Terminal is taken from the live feedback so the enable is withdrawn
    // in the same cycle the counter arrives; the counter never overshoots.
    assign w_terminal = r_dir ? cnt_tc : (cnt_q == C_ZERO);

    // abort in IDLE outranks start.
    assign w_accept      = (r_state == ST_IDLE) && start && !abort;

    assign w_load_shadow = (r_state == ST_LOAD) && !abort;

    // A counting cycle: the enable is actually driven low to the counter.
    assign w_step        = (r_state == ST_RUN) && !abort && !w_mismatch &&
                           !w_terminal && !hold;

    assign w_set_err     = (r_state == ST_RUN) && !abort && w_mismatch;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and counter controls.
    // Every output is decoded from the state register plus abort/hold, so
    // the asynchronous reset of r_state takes all of them straight to
    // their idle values without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        par_data     = C_ZERO;
        load_n       = 1'b1;
        cnt_en_n     = 1'b1;
        up_downbar   = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_LOAD;
                end
            end

            ST_LOAD: begin
                busy       = 1'b1;
                up_downbar = r_dir;
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else begin
                    load_n       = 1'b0;
                    par_data     = r_val;
                    w_next_state = ST_RUN;
                end
            end

            ST_RUN: begin
                busy       = 1'b1;
                up_downbar = r_dir;
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_mismatch) begin
                    w_next_state = ST_ERR;
                end else if (w_terminal) begin
                    w_next_state = ST_DONE;
                end else if (!hold) begin
                    cnt_en_n = 1'b0;
                end
            end

            ST_DONE: begin
                // A start seen here is dropped; the block returns to IDLE
                // first and only then samples start again.
                busy         = 1'b1;
                up_downbar   = r_dir;
                done         = !abort;
                w_next_state = ST_IDLE;
            end

            ST_ERR: begin
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, shadow counter, tick counter and error flag.
    // ticks is only cleared by an accepted start, so after an abort it
    // keeps the partial count and after DONE it keeps the final count.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_val    <= C_ZERO;
            r_dir    <= 1'b1;
            r_shadow <= C_ZERO;
            r_ticks  <= C_ZERO;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_val   <= start_val;
                r_dir   <= dir_up;
                r_ticks <= C_ZERO;
                r_err   <= 1'b0;
            end

            if (w_load_shadow) begin
                r_shadow <= r_val;
            end else if (w_step) begin
                // Wraps modulo 2^WIDTH exactly like the counter itself.
                r_shadow <= r_dir ? (r_shadow + C_ONE) : (r_shadow - C_ONE);
            end

            if (w_step) begin
                r_ticks <= r_ticks + C_ONE;
            end

            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ticks = r_ticks;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr169_count_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr169_count_ctrl
//  Description : Self-checking bench for sr169_count_ctrl. A behavioural
//                169-style counter closes the loop; expected run results are
//                queued when a start is issued and compared when the run ends.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sr169_count_ctrl;

    localparam int WIDTH     = 4;
    localparam int C_MAX_CYC = 60;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             start      = 1'b0;
    logic             dir_up     = 1'b1;
    logic             hold       = 1'b0;
    logic             abort      = 1'b0;
    logic [WIDTH-1:0] start_val  = '0;
    logic [WIDTH-1:0] cnt_q      = '0;
    logic             cnt_tc     = 1'b0;
    logic [WIDTH-1:0] par_data;
    logic [WIDTH-1:0] ticks;
    logic             load_n;
    logic             cnt_en_n;
    logic             up_downbar;
    logic             busy;
    logic             done;
    logic             err;

    int n_cmp   = 0;
    int n_bad   = 0;
    int skip_at = -1;   // counter value at which the model jumps by two

    // kind: 0 = done, 1 = error exit, 2 = timed out before done or error
    typedef struct {
        int kind;
        int ticks;
        int lat;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] q_seen[$];

    sr169_count_ctrl #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_val  (start_val),
        .dir_up     (dir_up),
        .hold       (hold),
        .abort      (abort),
        .cnt_q      (cnt_q),
        .cnt_tc     (cnt_tc),
        .par_data   (par_data),
        .load_n     (load_n),
        .cnt_en_n   (cnt_en_n),
        .up_downbar (up_downbar),
        .busy       (busy),
        .done       (done),
        .ticks      (ticks),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Behavioural 169-style counter; TC is registered alongside Q.
    always @(posedge clock) begin : counter_model
        logic [WIDTH-1:0] qn;
        qn = cnt_q;
        if (!load_n) begin
            qn = par_data;
        end else if (!cnt_en_n) begin
            if (up_downbar) begin
                qn = (int'(cnt_q) == skip_at) ? cnt_q + WIDTH'(2) : cnt_q + WIDTH'(1);
            end else begin
                qn = cnt_q - WIDTH'(1);
            end
        end
        cnt_q  <= qn;
        cnt_tc <= up_downbar ? (qn == '1) : (qn == '0);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues a one-cycle start; leaves the bench in the LOAD cycle.
    task automatic send_start(input logic [WIDTH-1:0] val, input logic up,
                              input bit track, input int kind,
                              input int exp_ticks, input int exp_lat);
        exp_t e;
        start_val = val;
        dir_up    = up;
        start     = 1'b1;
        if (track) begin
            e.kind  = kind;
            e.ticks = exp_ticks;
            e.lat   = exp_lat;
            sb.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    // Observes a run from the LOAD cycle until done or the error exit.
    // lat counts cycles after the start cycle.
    task automatic wait_end(output int kind, output int lat, output int n_en);
        kind = 2;
        lat  = 1;
        n_en = 0;
        q_seen.delete();
        while (lat <= C_MAX_CYC) begin
            if (done) begin
                kind = 0;
                break;
            end
            if (err && !busy) begin
                kind = 1;
                break;
            end
            if (!cnt_en_n) n_en++;
            if (busy && load_n) q_seen.push_back(cnt_q);
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        logic [2*WIDTH+5:0] obs;
        reset = 1'b1;
        #2;
        obs = {load_n, cnt_en_n, up_downbar, busy, done, err, par_data, ticks};
        n_cmp++;
        if (obs !== {3'b111, 3'b000, {WIDTH{1'b0}}, {WIDTH{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset_values: got %b, expected 111000_0000_0000", obs);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        obs = {load_n, cnt_en_n, up_downbar, busy, done, err, par_data, ticks};
        n_cmp++;
        if (obs !== {3'b111, 3'b000, {WIDTH{1'b0}}, {WIDTH{1'b0}}}) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b, expected 111000_0000_0000", obs);
        end
    endtask

    task automatic test_count_up();
        exp_t e;
        int   k, l, n;
        send_start(4'd12, 1'b1, 1'b1, 0, 3, 6);
        n_cmp++;
        if (load_n !== 1'b0 || par_data !== 4'd12 || up_downbar !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL up_load: load_n=%b par=%0d ud=%b busy=%b, expected 0 12 1 1",
                     load_n, par_data, up_downbar, busy);
        end
        wait_end(k, l, n);
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat) begin
            n_bad++;
            $display("FAIL up_end: kind=%0d lat=%0d, expected kind=%0d lat=%0d", k, l, e.kind, e.lat);
        end
        n_cmp++;
        if (int'(ticks) !== e.ticks || err !== 1'b0) begin
            n_bad++;
            $display("FAIL up_ticks: ticks=%0d err=%b, expected %0d 0", ticks, err, e.ticks);
        end
        n_cmp++;
        if (n !== 3) begin
            n_bad++;
            $display("FAIL up_enables: got %0d enable cycles, expected 3", n);
        end
        n_cmp++;
        if (q_seen.size() != 4 || {q_seen[0], q_seen[1], q_seen[2], q_seen[3]} !== 16'hCDEF) begin
            n_bad++;
            $display("FAIL up_q_seq: size=%0d, expected 12,13,14,15", q_seen.size());
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || up_downbar !== 1'b1) begin
            n_bad++;
            $display("FAIL up_idle: busy=%b done=%b ud=%b, expected 0 0 1", busy, done, up_downbar);
        end
    endtask

    task automatic test_count_down();
        exp_t e;
        int   k, l, n;
        send_start(4'd3, 1'b0, 1'b1, 0, 3, 6);
        n_cmp++;
        if (up_downbar !== 1'b0 || par_data !== 4'd3 || load_n !== 1'b0) begin
            n_bad++;
            $display("FAIL down_load: ud=%b par=%0d load_n=%b, expected 0 3 0", up_downbar, par_data, load_n);
        end
        wait_end(k, l, n);
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat || int'(ticks) !== e.ticks) begin
            n_bad++;
            $display("FAIL down_end: kind=%0d lat=%0d ticks=%0d, expected %0d %0d %0d",
                     k, l, ticks, e.kind, e.lat, e.ticks);
        end
        n_cmp++;
        if (q_seen.size() != 4 || {q_seen[0], q_seen[1], q_seen[2], q_seen[3]} !== 16'h3210) begin
            n_bad++;
            $display("FAIL down_q_seq: size=%0d, expected 3,2,1,0", q_seen.size());
        end
        tick();
        n_cmp++;
        if (up_downbar !== 1'b1) begin
            n_bad++;
            $display("FAIL down_dir_release: ud=%b, expected 1", up_downbar);
        end
        // Already at terminal: one RUN cycle, no enables.
        send_start(4'd0, 1'b0, 1'b1, 0, 0, 3);
        wait_end(k, l, n);
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat || int'(ticks) !== e.ticks || n !== 0) begin
            n_bad++;
            $display("FAIL down_zero: kind=%0d lat=%0d ticks=%0d en=%0d, expected %0d %0d %0d 0",
                     k, l, ticks, n, e.kind, e.lat, e.ticks);
        end
        tick();
    endtask

    task automatic test_hold();
        exp_t e;
        int   k, l, n;
        send_start(4'd5, 1'b1, 1'b1, 0, 10, 17);
        fork
            wait_end(k, l, n);
            begin
                logic [WIDTH-1:0] q0;
                repeat (3) @(posedge clock);
                #1 hold = 1'b1;
                #1 q0 = cnt_q;
                for (int i = 0; i < 4; i++) begin
                    n_cmp++;
                    if (cnt_en_n !== 1'b1 || cnt_q !== q0) begin
                        n_bad++;
                        $display("FAIL hold_freeze[%0d]: en_n=%b q=%0d, expected 1 %0d", i, cnt_en_n, cnt_q, q0);
                    end
                    if (i < 3) begin
                        @(posedge clock);
                        #2;
                    end
                end
                @(posedge clock);
                #1 hold = 1'b0;
            end
        join
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat || int'(ticks) !== e.ticks) begin
            n_bad++;
            $display("FAIL hold_end: kind=%0d lat=%0d ticks=%0d, expected %0d %0d %0d",
                     k, l, ticks, e.kind, e.lat, e.ticks);
        end
        tick();
    endtask

    task automatic test_error();
        exp_t e;
        int   k, l, n;
        skip_at = 10;
        send_start(4'd8, 1'b1, 1'b1, 1, -1, 6);
        wait_end(k, l, n);
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat) begin
            n_bad++;
            $display("FAIL err_exit: kind=%0d lat=%0d, expected kind=%0d lat=%0d", k, l, e.kind, e.lat);
        end
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cnt_en_n !== 1'b1) begin
            n_bad++;
            $display("FAIL err_outputs: err=%b busy=%b done=%b en_n=%b, expected 1 0 0 1",
                     err, busy, done, cnt_en_n);
        end
        skip_at = -1;
        tick();
        n_cmp++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_sticky: err=%b busy=%b, expected 1 0", err, busy);
        end
        send_start(4'd8, 1'b1, 1'b1, 0, 7, 10);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b, expected 0", err);
        end
        wait_end(k, l, n);
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat || int'(ticks) !== e.ticks) begin
            n_bad++;
            $display("FAIL err_rerun: kind=%0d lat=%0d ticks=%0d, expected %0d %0d %0d",
                     k, l, ticks, e.kind, e.lat, e.ticks);
        end
        tick();
    endtask

    task automatic test_abort();
        int saw_done;
        send_start(4'd0, 1'b1, 1'b0, 0, 0, 0);
        tick();
        tick();
        tick();
        abort = 1'b1;
        #1;
        n_cmp++;
        if (cnt_en_n !== 1'b1 || load_n !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_gate: en_n=%b load_n=%b done=%b, expected 1 1 0", cnt_en_n, load_n, done);
        end
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) saw_done++;
            tick();
        end
        n_cmp++;
        if (saw_done !== 0 || ticks !== 4'd2) begin
            n_bad++;
            $display("FAIL abort_partial: done_cycles=%0d ticks=%0d, expected 0 2", saw_done, ticks);
        end
        start_val = 4'd5;
        dir_up    = 1'b1;
        start     = 1'b1;
        abort     = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || load_n !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_beats_start: busy=%b load_n=%b, expected 0 1", busy, load_n);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || ticks !== 4'd2) begin
            n_bad++;
            $display("FAIL abort_no_run: busy=%b ticks=%0d, expected 0 2", busy, ticks);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t               e;
        int                 k, l, n;
        logic [2*WIDTH+5:0] obs;
        send_start(4'd3, 1'b1, 1'b0, 0, 0, 0);
        tick();
        tick();
        #3 reset = 1'b1;
        #1;
        obs = {load_n, cnt_en_n, up_downbar, busy, done, err, par_data, ticks};
        n_cmp++;
        if (obs !== {3'b111, 3'b000, {WIDTH{1'b0}}, {WIDTH{1'b0}}}) begin
            n_bad++;
            $display("FAIL async_reset: got %b, expected 111000_0000_0000", obs);
        end
        tick();
        reset = 1'b0;
        tick();
        send_start(4'd14, 1'b1, 1'b1, 0, 1, 4);
        wait_end(k, l, n);
        e = sb.pop_front();
        n_cmp++;
        if (k !== e.kind || l !== e.lat || int'(ticks) !== e.ticks) begin
            n_bad++;
            $display("FAIL post_reset_run: kind=%0d lat=%0d ticks=%0d, expected %0d %0d %0d",
                     k, l, ticks, e.kind, e.lat, e.ticks);
        end
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_count_up();
        test_count_down();
        test_hold();
        test_error();
        test_abort();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr169_count_ctrl.md
Name: sr169_count_ctrl

Overview:
Initiator/driver for the team's 4-bit loadable up/down counter interface (active-low load, active-low count enable, up_downbar direction, Q and registered TC back). It accepts a count request on a start/busy handshake, loads the counter, and enables counting until the terminal value. It then pulses done with the number of ticks issued. It shadows the expected counter value every cycle and flags an error if the counter disagrees. It sits between the control unit and a 169-style counter used for loop and delay sequencing.

Parameters:
WIDTH, 4, counter width. Sizes par_data, cnt_q, start_val, ticks and the shadow register.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  request strobe; sampled only in IDLE
start_val  in  WIDTH  value to load into counter
dir_up  in  1  1 = count up to all-ones (TC); 0 = count down to zero
hold  in  1  pause counting while high (RUN only)
abort  in  1  cancel operation; priority over everything except reset
cnt_q  in  WIDTH  counter Q
cnt_tc  in  1  counter terminal count (registered, aligned with Q)
par_data  out  WIDTH  counter parallel input
load_n  out  1  counter parallel_enable, active low
cnt_en_n  out  1  counter count_en, active low
up_downbar  out  1  counter direction
busy  out  1  high from LOAD through DONE inclusive
done  out  1  one-cycle completion pulse
ticks  out  WIDTH  enables issued in the last completed run; valid from done, held until next start
err  out  1  sticky mismatch flag; cleared by the next accepted start or by reset

Behaviour:
- Reset (async, high) forces the following values:
  - state=IDLE, load_n=1, cnt_en_n=1, up_downbar=1, par_data=0
  - busy=0, done=0, ticks=0, err=0, shadow=0
- States: IDLE, LOAD, RUN, DONE, ERR.
- IDLE:
  - All counter controls are inactive.
  - When start=1, latch start_val and dir_up, clear err and the tick counter, then go to LOAD.
- LOAD (1 cycle):
  - Drive load_n=0, par_data=latched value, up_downbar=latched dir.
  - Set shadow=latched value, then go to RUN.
  - Counter Q reflects the loaded value in the first RUN cycle.
- RUN, every cycle:
  - Compare: if cnt_q != shadow, or (dir up and cnt_tc != (cnt_q==all-ones)), go to ERR.
  - Terminal: up means cnt_tc=1; down means cnt_q=0. Terminal goes to DONE with cnt_en_n=1 (combinational, so no overshoot).
  - Otherwise, if hold=0, drive cnt_en_n=0, step shadow +1 (up) or -1 (down) modulo 2^WIDTH, and increment ticks.
  - Otherwise (hold=1), drive cnt_en_n=1; shadow and ticks are unchanged.
- Boundary cases:
  - A load value already at terminal (15 up, 0 down) gives DONE after exactly one RUN cycle with ticks=0.
  - Latency is start accepted to done = 3 + N cycles with no holds, where N = 15-start_val (up) or start_val (down).
- DONE (1 cycle):
  - done=1, busy=1, then go to IDLE. A start in this cycle is ignored.
- ERR:
  - Set err=1, counter controls inactive, busy=0, then go to IDLE on the next cycle.
  - done is not asserted; err stays high until the next accepted start.
- abort=1 in LOAD/RUN/DONE:
  - Next state is IDLE, controls go inactive immediately (combinational gating), and there is no done.
  - ticks holds the partial count.
  - abort in IDLE wins over start.
- up_downbar holds the latched direction from LOAD until return to IDLE, then returns to 1.
- Reset mid-operation: outputs go to reset values asynchronously. The counter's own state is not touched; the next run reloads it.

Test Plan:
1. Reset, start_val=12, dir_up=1, no hold -> load_n low 1 cycle with par_data=12; cnt_en_n low 3 cycles; cnt_q 12,13,14,15; done 6 cycles after start; ticks=3; err=0.
2. start_val=3, dir_up=0 -> up_downbar=0; cnt_q 3,2,1,0; done after 3 ticks; ticks=3. Repeat with start_val=0 -> done with ticks=0, cnt_en_n never low.
3. Up run from 5 with hold high for 4 cycles mid-run -> cnt_q frozen during hold, cnt_en_n=1; final ticks=10; done latency 3+10+4 cycles.
4. Up run from 8; bench model forces cnt_q to skip one value -> err=1 next cycle, busy drops, no done; next start clears err and completes normally.
5. Abort asserted 2 cycles into RUN from 0 up -> cnt_en_n=1 same cycle, IDLE next, done never pulses; start and abort together in IDLE -> start ignored.
6. Async reset asserted mid-RUN between clock edges -> all outputs at reset values before the next edge; a subsequent start from 14 up completes with ticks=1.
